// File: rtl/turbo_encoder.sv
// Rate-1/3 parallel-concatenated turbo encoder: two g=(7,5) RSC encoders, the second fed
// through an additive interleaver pi(i) = i*P mod K, with trellis termination of both RSCs.
module turbo_encoder #(
   parameter int K = 40,
   parameter int P = 13
) (
   input  logic clk,
   input  logic rst,
   input  logic in_bit,
   input  logic in_valid,
   output logic in_ready,
   output logic out_x,
   output logic out_p1,
   output logic out_p2,
   output logic out_valid,
   input  logic out_ready,
   output logic out_sop,
   output logic out_eop,
   output logic out_tail
);

   localparam int AW = $clog2(K);
   localparam int CW = $clog2(K + 4);

   localparam logic [AW:0]   P_W      = (AW + 1)'(P);
   localparam logic [AW:0]   K_W      = (AW + 1)'(K);
   localparam logic [AW-1:0] LAST_WR  = AW'(K - 1);
   localparam logic [CW-1:0] LAST_ENC = CW'(K - 1);
   localparam logic [CW-1:0] LAST_T1  = CW'(K + 1);
   localparam logic [CW-1:0] LAST_SYM = CW'(K + 3);

   typedef enum logic [1:0] {LOAD, ENC, TAIL1, TAIL2} state_t;

   state_t          state_q, state_d;
   logic [K-1:0]    buf_q, buf_d;
   logic [AW-1:0]   wr_cnt_q, wr_cnt_d;
   logic [AW-1:0]   pi_q, pi_d;
   logic [CW-1:0]   sym_cnt_q, sym_cnt_d;
   logic [1:0]      rsc1_q, rsc1_d;
   logic [1:0]      rsc2_q, rsc2_d;
   logic            x_q, x_d, p1_q, p1_d, p2_q, p2_d;
   logic            sop_q, sop_d, eop_q, eop_d, tail_q, tail_d, valid_q, valid_d;

   logic            load_en;
   logic            u1, u2;
   logic [2:0]      r1, r2;
   logic [AW:0]     pi_sum, pi_wrap;

   // One trellis step of the (7,5) RSC; state is {s1,s2}, result is {parity, next s1, next s2}.
   function automatic logic [2:0] rsc_step(input logic u, input logic [1:0] s);
      logic a;
      a = u ^ s[1] ^ s[0];
      return {a ^ s[0], a, s[1]};
   endfunction

   assign in_ready  = (state_q == LOAD);
   assign load_en   = !valid_q || out_ready;

   assign out_x     = x_q;
   assign out_p1    = p1_q;
   assign out_p2    = p2_q;
   assign out_sop   = sop_q;
   assign out_eop   = eop_q;
   assign out_tail  = tail_q;
   assign out_valid = valid_q;

   always_comb begin
      state_d   = state_q;
      buf_d     = buf_q;
      wr_cnt_d  = wr_cnt_q;
      pi_d      = pi_q;
      sym_cnt_d = sym_cnt_q;
      rsc1_d    = rsc1_q;
      rsc2_d    = rsc2_q;
      x_d       = x_q;
      p1_d      = p1_q;
      p2_d      = p2_q;
      sop_d     = sop_q;
      eop_d     = eop_q;
      tail_d    = tail_q;
      valid_d   = valid_q;
      u1        = 1'b0;
      u2        = 1'b0;
      r1        = 3'b000;
      r2        = 3'b000;
      // Interleaver address advances by P modulo K without a divider.
      pi_sum    = {1'b0, pi_q} + P_W;
      pi_wrap   = (pi_sum >= K_W) ? (pi_sum - K_W) : pi_sum;

      case (state_q)
         LOAD: begin
            if (load_en) valid_d = 1'b0;
            if (in_valid) begin
               buf_d[wr_cnt_q] = in_bit;
               if (wr_cnt_q == LAST_WR) begin
                  wr_cnt_d = '0;
                  state_d  = ENC;
               end else begin
                  wr_cnt_d = wr_cnt_q + 1'b1;
               end
            end
         end
         ENC: begin
            if (load_en) begin
               u1        = buf_q[sym_cnt_q[AW-1:0]];
               u2        = buf_q[pi_q];
               r1        = rsc_step(u1, rsc1_q);
               r2        = rsc_step(u2, rsc2_q);
               rsc1_d    = r1[1:0];
               rsc2_d    = r2[1:0];
               x_d       = u1;
               p1_d      = r1[2];
               p2_d      = r2[2];
               sop_d     = (sym_cnt_q == '0);
               eop_d     = 1'b0;
               tail_d    = 1'b0;
               valid_d   = 1'b1;
               pi_d      = pi_wrap[AW-1:0];
               sym_cnt_d = sym_cnt_q + 1'b1;
               if (sym_cnt_q == LAST_ENC) state_d = TAIL1;
            end
         end
         TAIL1: begin
            if (load_en) begin
               // Feeding back s1^s2 zeroes the recursion input, flushing the register in two steps.
               u1        = rsc1_q[1] ^ rsc1_q[0];
               r1        = rsc_step(u1, rsc1_q);
               rsc1_d    = r1[1:0];
               x_d       = u1;
               p1_d      = r1[2];
               p2_d      = 1'b0;
               sop_d     = 1'b0;
               eop_d     = 1'b0;
               tail_d    = 1'b1;
               valid_d   = 1'b1;
               sym_cnt_d = sym_cnt_q + 1'b1;
               if (sym_cnt_q == LAST_T1) state_d = TAIL2;
            end
         end
         TAIL2: begin
            if (load_en) begin
               u2        = rsc2_q[1] ^ rsc2_q[0];
               r2        = rsc_step(u2, rsc2_q);
               rsc2_d    = r2[1:0];
               x_d       = u2;
               p1_d      = 1'b0;
               p2_d      = r2[2];
               sop_d     = 1'b0;
               eop_d     = (sym_cnt_q == LAST_SYM);
               tail_d    = 1'b1;
               valid_d   = 1'b1;
               sym_cnt_d = sym_cnt_q + 1'b1;
               if (sym_cnt_q == LAST_SYM) begin
                  state_d   = LOAD;
                  sym_cnt_d = '0;
                  pi_d      = '0;
                  rsc1_d    = 2'b00;
                  rsc2_d    = 2'b00;
               end
            end
         end
         default: state_d = LOAD;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= LOAD;
         wr_cnt_q  <= '0;
         pi_q      <= '0;
         sym_cnt_q <= '0;
         rsc1_q    <= 2'b00;
         rsc2_q    <= 2'b00;
         x_q       <= 1'b0;
         p1_q      <= 1'b0;
         p2_q      <= 1'b0;
         sop_q     <= 1'b0;
         eop_q     <= 1'b0;
         tail_q    <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         pi_q      <= pi_d;
         sym_cnt_q <= sym_cnt_d;
         rsc1_q    <= rsc1_d;
         rsc2_q    <= rsc2_d;
         x_q       <= x_d;
         p1_q      <= p1_d;
         p2_q      <= p2_d;
         sop_q     <= sop_d;
         eop_q     <= eop_d;
         tail_q    <= tail_d;
         valid_q   <= valid_d;
      end
   end

   // Frame buffer holds data only; a reset leaves it stale and the next frame overwrites it.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

endmodule

// File: tb/tb_turbo_encoder.sv
// Directed bench for turbo_encoder (K=40, P=13): reset, latency, zero frame, an impulse at
// every bit position, backpressure stalls and reset in the middle of a frame.
module tb_turbo_encoder;

   localparam int K = 40;
   localparam int P = 13;

   logic clk = 1'b0;
   logic rst, in_bit, in_valid, in_ready;
   logic out_x, out_p1, out_p2, out_valid, out_ready, out_sop, out_eop, out_tail;

   int checks   = 0;
   int failures = 0;

   turbo_encoder #(.K(K), .P(P)) dut (
      .clk(clk), .rst(rst), .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready),
      .out_x(out_x), .out_p1(out_p1), .out_p2(out_p2), .out_valid(out_valid),
      .out_ready(out_ready), .out_sop(out_sop), .out_eop(out_eop), .out_tail(out_tail)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Parity of an RSC excited by a single 1 at step i0: 1 at i0, then period-3 pattern 1,1,0.
   function automatic logic imp_par(input int i, input int i0);
      int j;
      if (i0 < 0 || i < i0) return 1'b0;
      j = i - i0;
      if (j == 0) return 1'b1;
      return (j % 3 != 0);
   endfunction

   // RSC state {s1,s2} after step i0+j of an impulse: cycles 10,11,01.
   function automatic logic [1:0] imp_state(input int i0);
      int j;
      if (i0 < 0) return 2'b00;
      j = K - 1 - i0;
      if (j % 3 == 1) return 2'b11;
      if (j % 3 == 2) return 2'b01;
      return 2'b10;
   endfunction

   // Expected {x,p1,p2,sop,eop,tail} for symbol i of a frame whose only 1 is at bit b (b<0: none).
   function automatic logic [5:0] exp_vec(input int i, input int b, input int b2);
      logic [1:0] s1, s2;
      logic x, p1, p2;
      s1 = imp_state(b);
      s2 = imp_state(b2);
      x = 1'b0; p1 = 1'b0; p2 = 1'b0;
      if (i < K) begin
         x  = (i == b);
         p1 = imp_par(i, b);
         p2 = imp_par(i, b2);
      end else if (i == K) begin
         x = s1[1] ^ s1[0]; p1 = s1[0];
      end else if (i == K + 1) begin
         x = s1[1]; p1 = s1[1];
      end else if (i == K + 2) begin
         x = s2[1] ^ s2[0]; p2 = s2[0];
      end else begin
         x = s2[1]; p2 = s2[1];
      end
      return {x, p1, p2, (i == 0), (i == K + 3), (i >= K)};
   endfunction

   function automatic int pi_inv(input int b);
      int r;
      r = -1;
      for (int i = 0; i < K; i++) if ((i * P) % K == b) r = i;
      return r;
   endfunction

   task automatic send_frame(input int b);
      int guard;
      for (int k = 0; k < K; k++) begin
         in_bit   = (k == b);
         in_valid = 1'b1;
         guard    = 0;
         while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
         end
         if (guard >= 200) check("send_timeout", 32'(in_ready), 32'd1);
         @(negedge clk);
      end
      in_valid = 1'b0;
      in_bit   = 1'b0;
   endtask

   task automatic recv_frame(input int b, input bit stall);
      int sym, cyc, stall_left, bubbles, b2;
      bit s20_done, s40_done;
      logic [6:0] held, now_v;
      b2 = (b < 0) ? -1 : pi_inv(b);
      sym = 0; cyc = 0; stall_left = 0; bubbles = 0;
      s20_done = 1'b0; s40_done = 1'b0; held = '0;
      while (sym < K + 4 && cyc < 400) begin
         now_v = {out_x, out_p1, out_p2, out_sop, out_eop, out_tail, out_valid};
         if (!out_valid) begin
            if (sym > 0) bubbles++;
         end else if (stall_left > 0) begin
            check($sformatf("hold_b%0d_s%0d", b, sym), 32'(now_v), 32'(held));
            stall_left--;
            if (stall_left == 0) begin
               out_ready = 1'b1;
               check($sformatf("sym_b%0d_s%0d", b, sym), 32'(now_v[6:1]), 32'(exp_vec(sym, b, b2)));
               sym++;
            end
         end else if (stall && ((sym == 20 && !s20_done) || (sym == K && !s40_done))) begin
            if (sym == 20) s20_done = 1'b1; else s40_done = 1'b1;
            out_ready  = 1'b0;
            held       = now_v;
            stall_left = 3;
         end else begin
            check($sformatf("sym_b%0d_s%0d", b, sym), 32'(now_v[6:1]), 32'(exp_vec(sym, b, b2)));
            sym++;
         end
         @(negedge clk);
         cyc++;
      end
      if (sym < K + 4) check("recv_timeout", 32'(sym), 32'(K + 4));
      check($sformatf("bubbles_b%0d", b), 32'(bubbles), 32'd0);
      check($sformatf("idle_valid_b%0d", b), 32'(out_valid), 32'd0);
      check($sformatf("idle_ready_b%0d", b), 32'(in_ready), 32'd1);
   endtask

   initial begin
      int cnt;
      rst = 1'b0; in_bit = 1'b0; in_valid = 1'b0; out_ready = 1'b1;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({out_x, out_p1, out_p2, out_sop, out_eop, out_tail, out_valid}), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      check("reset_in_ready", 32'(in_ready), 32'd1);

      // All-zero frame with first-symbol latency
      send_frame(-1);
      check("latency_edge1_valid", 32'(out_valid), 32'd0);
      check("latency_edge1_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("latency_edge2_valid", 32'(out_valid), 32'd1);
      recv_frame(-1, 1'b0);

      // Impulse at every bit position exercises each interleaver address
      for (int b = 0; b < K; b++) begin
         send_frame(b);
         recv_frame(b, 1'b0);
      end

      // Backpressure at symbol 20 and in TAIL1
      send_frame(0);
      recv_frame(0, 1'b1);
      send_frame(13);
      recv_frame(13, 1'b1);

      // Reset while symbol 10 of a frame is presented
      send_frame(0);
      cnt = 0;
      while (cnt < 10 && checks < 100000) begin
         if (out_valid) cnt++;
         @(negedge clk);
         if (cnt == 0 && !out_valid && in_ready) break;
      end
      check("midenc_reached", 32'(cnt), 32'd10);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midenc_reset_outputs",
            32'({out_x, out_p1, out_p2, out_sop, out_eop, out_tail, out_valid}), 32'd0);
      check("midenc_in_ready", 32'(in_ready), 32'd1);
      @(negedge clk);
      check("midenc_no_more_valid", 32'(out_valid), 32'd0);
      send_frame(-1);
      recv_frame(-1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/turbo_encoder.md
TURBO_ENCODER -- requirements
Module: turbo_encoder

Interface
REQ-001 SHALL have parameter K, default 40, frame length in bits (K >= 8).
REQ-002 SHALL have parameter P, default 13, interleaver step (1 <= P < K, gcd(P,K)=1).
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port in_bit  input  1  information bit.
REQ-006 SHALL have port in_valid  input  1  in_bit is valid.
REQ-007 SHALL have port in_ready  output  1  block accepts in_bit.
REQ-008 SHALL have port out_x  output  1  systematic or tail-systematic bit.
REQ-009 SHALL have port out_p1  output  1  parity bit of RSC1 (natural order).
REQ-010 SHALL have port out_p2  output  1  parity bit of RSC2 (interleaved order).
REQ-011 SHALL have port out_valid  output  1  output symbol valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts the symbol.
REQ-013 SHALL have port out_sop  output  1  first symbol of frame.
REQ-014 SHALL have port out_eop  output  1  last symbol of frame (symbol K+3).
REQ-015 SHALL have port out_tail  output  1  symbol is a termination symbol.

Function
REQ-016 SHALL implement the FSM states LOAD, ENC, TAIL1, TAIL2, with in_ready=1 only in LOAD.
REQ-017 SHALL, in LOAD, on in_valid&&in_ready, write in_bit to buffer[wr_cnt] and increment wr_cnt; accepting the K-th bit SHALL clear wr_cnt and move to ENC.
REQ-018 SHALL implement each RSC as g=(7,5) octal with state (s1,s2): a=u^s1^s2, p=a^s2, next s1=a, s2=s1.
REQ-019 SHALL, in ENC symbol i (0..K-1), drive u1=buffer[i] to RSC1 and u2=buffer[pi(i)] to RSC2, and output x=u1, p1=RSC1 p, p2=RSC2 p.
REQ-020 SHALL compute pi incrementally: pi(0)=0, pi(i+1)=pi(i)+P, minus K if the sum is >= K; no multiplier or divider is permitted.
REQ-021 SHALL, in TAIL1 (2 symbols), drive RSC1 with u=s1^s2 and output x=u, p1=s2, p2=0, with RSC2 frozen.
REQ-022 SHALL, in TAIL2 (2 symbols), drive RSC2 the same way and output x=u, p1=0, p2=s2, with RSC1 frozen.
REQ-023 SHALL produce K+4 symbols per frame, ordered ENC(K), TAIL1(2), TAIL2(2); both RSC states SHALL be 00 after TAIL2.
REQ-024 SHALL register all outputs; a new symbol SHALL be loaded only when out_valid==0 or out_ready==1, and the encoder state and counters SHALL advance only on that load.
REQ-025 SHALL hold out_x, out_p1, out_p2, out_sop, out_eop, out_tail and out_valid stable while out_valid&&!out_ready.
REQ-026 SHALL assert out_valid in the cycle after the first edge spent in ENC, i.e. 2 edges after the K-th input handshake when out_ready=1.
REQ-027 SHALL, under continuous out_ready=1, emit one symbol per cycle with no bubbles across the ENC/TAIL1/TAIL2 boundaries.
REQ-028 SHALL set out_sop only with symbol 0, out_eop only with symbol K+3, and out_tail only with symbols K..K+3.
REQ-029 SHALL move to LOAD and clear both RSC states on the edge that loads symbol K+3.
REQ-030 SHALL deassert out_valid after symbol K+3 is accepted unless a new symbol is loaded on the same edge, which is impossible before K new inputs.
REQ-031 SHALL ignore in_bit whenever in_ready==0.

Reset
REQ-032 SHALL, while rst==0 at a clock edge, set state=LOAD, set wr_cnt, symbol counter, pi register and RSC states to 0, and set out_valid, out_x, out_p1, out_p2, out_sop, out_eop and out_tail to 0.
REQ-033 SHALL, on reset asserted mid-LOAD, mid-ENC or mid-TAIL, abort the frame with no further symbols and resume by accepting a fresh K-bit frame; buffer contents need not be cleared.
REQ-034 SHALL drive in_ready=1 in the first cycle after rst returns high.

Verification (K=40, P=13)
REQ-035 SHALL verify pi: 40 inputs -> internal pi sequence 0,13,26,39,12,25,38,11,...; each value 0..39 appears exactly once.
REQ-036 SHALL verify an all-zero frame: 40 zeros, out_ready=1 -> 44 symbols all 0; out_sop on symbol 0; out_tail on symbols 40-43; out_eop on symbol 43.
REQ-037 SHALL verify an impulse at bit 0: x0=1, else 0 -> p1[0..6]=1,1,1,0,1,1,0 and p2[0..6]=1,1,1,0,1,1,0; tail symbols terminate both RSCs to state 00.
REQ-038 SHALL verify an impulse at bit 13: only bit 13=1 -> p2[0..6]=0,1,1,1,0,1,1; p1 is 0 for i<13 and p1[13]=1.
REQ-039 SHALL verify backpressure: out_ready=0 for 3 cycles at symbol 20 and again during TAIL1 -> outputs held stable; 44-symbol sequence identical to the no-stall run.
REQ-040 SHALL verify reset mid-ENC: rst=0 for 1 cycle at symbol 10 -> next cycle out_valid=0 and in_ready=1; a following all-zero frame yields 44 zero symbols.
